sn_window_decoder: RTL and testbench
====================================

# sn_window_decoder

- Downstream stage of the stochastic multiplier: converts the serial bipolar stochastic bit stream into a binary result over a fixed-length observation window.
- Per window it produces two values: the unsigned ones-count and the signed bipolar value 2·ones − N.
- Window length is selectable at run time: 8, 16, 32 or 64 bits.
- Results are held in an output register under a valid/ready handshake, with sticky overrun detection.

## Interface
Parameters: none; all widths are fixed by the 64-bit maximum window.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear, highest priority after reset
- en  in  1  run enable; sampled only at window boundaries and in IDLE
- win_sel  in  2  window length N = 8 << win_sel (8/16/32/64); latched at window start
- sn_bit  in  1  stochastic bit from the multiplier
- sn_valid  in  1  qualifies sn_bit; bits count only when high
- out_ready  in  1  consumer accepts the result
- out_valid  out  1  result register holds an unaccepted result
- ones_out  out  7  ones counted in the last completed window, 0..64
- bipolar_out  out  8  signed two's complement, 2·ones_out − N, range −64..+64
- win_out  out  2  win_sel value used for the reported window
- overrun  out  1  sticky: a result was overwritten before acceptance
- busy  out  1  high in ACCUM

## Operation
FSM has two states, IDLE and ACCUM.

- **IDLE**
  - When en=1: latch win_sel into win_q, clear bit_cnt and ones_cnt, go to ACCUM.
  - sn_valid in this cycle is ignored.
- **ACCUM**
  - On each cycle with sn_valid=1: bit_cnt += 1 and ones_cnt += sn_bit.
  - Deasserting en or changing win_sel mid-window has no effect.
- **Final bit**: a valid bit accepted while bit_cnt == N−1. On that edge:
  - ones_out is loaded with ones_cnt + sn_bit; bipolar_out and win_out are loaded from it and win_q.
  - out_valid is set to 1.
  - bit_cnt and ones_cnt are cleared.
  - If en=1: re-latch win_sel and stay in ACCUM; the next valid bit, on the very next cycle, belongs to the new window (no gap).
  - If en=0: go to IDLE.
- **Width rules**
  - bit_cnt is 6 bits and never wraps; it is cleared exactly at N−1.
  - ones_cnt is 7 bits, since 64 must be representable.
  - bipolar_out = {ones,1'b0} − (8 << win_q), computed in 8 bits.
- **Handshake**
  - The transfer happens on an edge where out_valid && out_ready.
  - After a transfer, out_valid drops unless a new result loads on the same edge. In that case the new result is held, out_valid stays 1, and overrun is unchanged.
  - A new result loading while out_valid=1 and out_ready=0 overwrites the registers and sets overrun=1.
  - overrun clears only on clr or reset.
- **clr=1**
  - State goes to IDLE.
  - bit_cnt, ones_cnt, ones_out, bipolar_out, win_out, out_valid and overrun all go to 0.
  - clr overrides any simultaneous completion or transfer.
- **Reset (rst_n low)**: immediate, with the same values as clr. A window in progress is discarded.

## Timing
- Reset values: out_valid=0, ones_out=0, bipolar_out=0, win_out=0, overrun=0, busy=0, state IDLE.
- Startup: en=1 sampled at edge E0 puts the block in ACCUM after E0. Bits are sampled at E1 onward.
- Latency: with continuous sn_valid, the result appears after edge E_N, meaning out_valid is high in the cycle following the N-th valid bit. Continuous windows then complete every N cycles.
- sn_valid gaps stretch the window; only valid bits count.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Saturation high**: win_sel=0, en=1, sn_valid=1, sn_bit=1 constant, out_ready=1 → every 8 cycles a one-cycle out_valid pulse with ones_out=8, bipolar_out=+8 (0x08), win_out=0, overrun=0.
- **Saturation low**: win_sel=3, sn_bit=0 for 64 valid cycles → ones_out=0, bipolar_out=−64 (0xC0), win_out=3.
- **Gaps, zero result**: win_sel=1, sn_valid toggling 1/0, sn_bit pattern 1,0,1,0 on valid cycles → result after 16 valid bits (about 32 cycles), ones_out=8, bipolar_out=0.
- **Overrun**: win_sel=0, out_ready=0 for two windows of all ones → after the second window, out_valid=1, ones_out=8 from the second window, overrun=1. Then out_ready=1 for one cycle → out_valid=0 while overrun stays 1. Then clr → overrun=0.
- **Boundary latching**: win_sel changed from 0 to 2 at bit 4 of an 8-bit window → the current window completes at 8 bits with win_out=0. The next window is 32 bits with win_out=2. Also, completion and out_ready on the same edge → out_valid stays 1 with no overrun.
- **Reset mid-window**: rst_n pulsed low at bit 5 of a 16-bit window → all outputs go to 0 immediately. After release, with en=1, a fresh window is counted from zero with no stale ones.

Source files
------------

// File: rtl/sn_window_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sn_window_decoder_if
//  Description : Stream-in / result-out bundle of the stochastic window decoder.
//                master = decoder side (consumes bits, sources results),
//                slave  = environment side (sources bits, consumes results).
//  Revision    : 1.0  initial release
// ============================================================================
interface sn_window_decoder_if;
    logic       sn_bit;
    logic       sn_valid;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] ones_out;
    logic [7:0] bipolar_out;
    logic [1:0] win_out;

    modport master (
        input  sn_bit,
        input  sn_valid,
        input  out_ready,
        output out_valid,
        output ones_out,
        output bipolar_out,
        output win_out
    );

    modport slave (
        output sn_bit,
        output sn_valid,
        output out_ready,
        input  out_valid,
        input  ones_out,
        input  bipolar_out,
        input  win_out
    );
endinterface
`default_nettype wire

// File: rtl/sn_window_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sn_window_decoder
//  Description : Converts a serial bipolar stochastic bit stream into a ones
//                count and a signed bipolar value (2*ones - N) over a run-time
//                selectable window of 8/16/32/64 valid bits. Results sit in a
//                valid/ready output register with sticky overrun detection.
//  Revision    : 1.0  initial release
// ============================================================================
module sn_window_decoder (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               clr,
    input  wire logic               en,
    input  wire logic [1:0]         win_sel,
    sn_window_decoder_if.master     bus,
    output logic                    overrun,
    output logic                    busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_win_q;
    logic [5:0] r_bit_cnt;
    logic [6:0] r_ones_cnt;
    logic       r_out_valid;
    logic [6:0] r_ones_out;
    logic [7:0] r_bipolar_out;
    logic [1:0] r_win_out;
    logic       r_overrun;
    logic       r_busy;

    logic [5:0] w_last_idx;
    logic       w_final;
    logic [6:0] w_ones_final;
    logic [7:0] w_win_len;
    logic [7:0] w_bipolar;
    logic       w_xfer;

    // Index of the last bit in the latched window (N-1) and the window length N
    always_comb begin
        w_last_idx = 6'd7;
        w_win_len  = 8'd8;
        case (r_win_q)
            2'd0: begin w_last_idx = 6'd7;  w_win_len = 8'd8;  end
            2'd1: begin w_last_idx = 6'd15; w_win_len = 8'd16; end
            2'd2: begin w_last_idx = 6'd31; w_win_len = 8'd32; end
            2'd3: begin w_last_idx = 6'd63; w_win_len = 8'd64; end
            default: begin w_last_idx = 6'd7; w_win_len = 8'd8; end
        endcase
    end

    // Final-bit detection and the result that loads on that edge
    always_comb begin
        w_final      = (r_state == ACCUM) && bus.sn_valid && (r_bit_cnt == w_last_idx);
        w_ones_final = r_ones_cnt + {6'd0, bus.sn_bit};
        w_bipolar    = {w_ones_final, 1'b0} - w_win_len;
        w_xfer       = r_out_valid && bus.out_ready;
    end

    // Window FSM, counters and the handshaked result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_win_q       <= 2'd0;
            r_bit_cnt     <= 6'd0;
            r_ones_cnt    <= 7'd0;
            r_out_valid   <= 1'b0;
            r_ones_out    <= 7'd0;
            r_bipolar_out <= 8'd0;
            r_win_out     <= 2'd0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else if (clr) begin
            r_state       <= IDLE;
            r_win_q       <= 2'd0;
            r_bit_cnt     <= 6'd0;
            r_ones_cnt    <= 7'd0;
            r_out_valid   <= 1'b0;
            r_ones_out    <= 7'd0;
            r_bipolar_out <= 8'd0;
            r_win_out     <= 2'd0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // A transfer drops valid; a same-edge completion below re-asserts it
            if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_win_q    <= win_sel;
                        r_bit_cnt  <= 6'd0;
                        r_ones_cnt <= 7'd0;
                        r_state    <= ACCUM;
                        r_busy     <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (w_final) begin
                        r_ones_out    <= w_ones_final;
                        r_bipolar_out <= w_bipolar;
                        r_win_out     <= r_win_q;
                        r_out_valid   <= 1'b1;
                        // Overwriting a result nobody has taken is sticky
                        if (r_out_valid && !bus.out_ready) begin
                            r_overrun <= 1'b1;
                        end
                        r_bit_cnt  <= 6'd0;
                        r_ones_cnt <= 7'd0;
                        if (en) begin
                            r_win_q <= win_sel;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (bus.sn_valid) begin
                        r_bit_cnt  <= r_bit_cnt + 6'd1;
                        r_ones_cnt <= w_ones_final;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.ones_out    = r_ones_out;
    assign bus.bipolar_out = r_bipolar_out;
    assign bus.win_out     = r_win_out;
    assign overrun         = r_overrun;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sn_window_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn_window_decoder
//  Description : Self-checking bench for sn_window_decoder: a table of single
//                windows with hand-computed results, plus hand-written
//                sequences for back-to-back windows, overrun, boundary
//                latching and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sn_window_decoder;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic [1:0] win_sel;
    logic       overrun;
    logic       busy;

    sn_window_decoder_if u_if ();

    sn_window_decoder u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (en),
        .win_sel (win_sel),
        .bus     (u_if.master),
        .overrun (overrun),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  win;
        logic [63:0] bits;
        logic        gaps;
        logic [6:0]  ones;
        logic [7:0]  bip;
    } vec_t;

    vec_t tbl [9];

    int n_vec;
    int n_miss;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int n;
        n_vec  = 0;
        n_miss = 0;

        tbl[0] = '{2'd0, 64'h0000_0000_0000_00FF, 1'b0, 7'd8,  8'h08};
        tbl[1] = '{2'd3, 64'h0000_0000_0000_0000, 1'b0, 7'd0,  8'hC0};
        tbl[2] = '{2'd1, 64'h0000_0000_0000_5555, 1'b1, 7'd8,  8'h00};
        tbl[3] = '{2'd2, 64'h0000_0000_0000_000F, 1'b0, 7'd4,  8'hE8};
        tbl[4] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd64, 8'h40};
        tbl[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FF01, 1'b1, 7'd1,  8'hFA};
        tbl[6] = '{2'd1, 64'h0000_0000_0000_0FFF, 1'b0, 7'd12, 8'h08};
        tbl[7] = '{2'd3, 64'h0000_0000_FFFF_FFFF, 1'b1, 7'd32, 8'h00};
        tbl[8] = '{2'd2, 64'h0000_0000_FFFF_FFFE, 1'b0, 7'd31, 8'h1E};

        rst_n           = 1'b0;
        clr             = 1'b0;
        en              = 1'b0;
        win_sel         = 2'd0;
        u_if.sn_bit     = 1'b0;
        u_if.sn_valid   = 1'b0;
        u_if.out_ready  = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_out_valid", {15'd0, u_if.out_valid}, 16'd0);
        check("rst_ones",      {9'd0, u_if.ones_out},   16'd0);
        check("rst_bipolar",   {8'd0, u_if.bipolar_out}, 16'd0);
        check("rst_win",       {14'd0, u_if.win_out},   16'd0);
        check("rst_overrun",   {15'd0, overrun},        16'd0);
        check("rst_busy",      {15'd0, busy},           16'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- table: single windows ----------------
        for (int v = 0; v < 9; v++) begin
            n = 8 << tbl[v].win;
            en = 1'b1;
            win_sel = tbl[v].win;
            tick();
            check("tbl_busy_start", {15'd0, busy}, 16'd1);
            en = 1'b0;
            win_sel = ~tbl[v].win;
            for (int i = 0; i < n; i++) begin
                if (tbl[v].gaps) begin
                    u_if.sn_valid = 1'b0;
                    u_if.sn_bit   = 1'b1;
                    tick();
                end
                u_if.sn_valid = 1'b1;
                u_if.sn_bit   = tbl[v].bits[i];
                tick();
            end
            u_if.sn_valid = 1'b0;
            check("tbl_valid",   {15'd0, u_if.out_valid},  16'd1);
            check("tbl_ones",    {9'd0, u_if.ones_out},    {9'd0, tbl[v].ones});
            check("tbl_bipolar", {8'd0, u_if.bipolar_out}, {8'd0, tbl[v].bip});
            check("tbl_win",     {14'd0, u_if.win_out},    {14'd0, tbl[v].win});
            check("tbl_busy_end",{15'd0, busy},            16'd0);
            check("tbl_overrun", {15'd0, overrun},         16'd0);
            u_if.out_ready = 1'b1;
            tick();
            u_if.out_ready = 1'b0;
            check("tbl_taken",   {15'd0, u_if.out_valid},  16'd0);
        end

        // ---------------- saturation high, back-to-back windows ----------------
        do_clr();
        win_sel        = 2'd0;
        en             = 1'b1;
        u_if.out_ready = 1'b1;
        tick();
        u_if.sn_valid = 1'b1;
        u_if.sn_bit   = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("sat_pulse", {15'd0, u_if.out_valid}, (k % 8 == 0) ? 16'd1 : 16'd0);
            if (k % 8 == 0) begin
                check("sat_ones", {9'd0, u_if.ones_out},    16'd8);
                check("sat_bip",  {8'd0, u_if.bipolar_out}, 16'h08);
            end
        end
        check("sat_overrun", {15'd0, overrun}, 16'd0);
        u_if.sn_valid = 1'b0;
        en = 1'b0;
        do_clr();

        // ---------------- overrun ----------------
        u_if.out_ready = 1'b0;
        win_sel = 2'd0;
        en = 1'b1;
        tick();
        u_if.sn_valid = 1'b1;
        u_if.sn_bit   = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("ovr_first_no_ovr", {15'd0, overrun}, 16'd0);
        for (int k = 0; k < 8; k++) tick();
        u_if.sn_valid = 1'b0;
        check("ovr_valid",   {15'd0, u_if.out_valid}, 16'd1);
        check("ovr_ones",    {9'd0, u_if.ones_out},   16'd8);
        check("ovr_flag",    {15'd0, overrun},        16'd1);
        u_if.out_ready = 1'b1;
        tick();
        u_if.out_ready = 1'b0;
        check("ovr_taken",   {15'd0, u_if.out_valid}, 16'd0);
        check("ovr_sticky",  {15'd0, overrun},        16'd1);
        en = 1'b0;
        do_clr();
        check("ovr_clr",     {15'd0, overrun},        16'd0);
        check("ovr_clr_busy",{15'd0, busy},           16'd0);

        // ---------------- boundary latching + same-edge transfer ----------------
        win_sel = 2'd0;
        en = 1'b1;
        u_if.out_ready = 1'b1;
        tick();
        u_if.sn_valid = 1'b1;
        u_if.sn_bit   = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) win_sel = 2'd2;
            tick();
        end
        check("bnd_valid1", {15'd0, u_if.out_valid}, 16'd1);
        check("bnd_win1",   {14'd0, u_if.win_out},   16'd0);
        check("bnd_ones1",  {9'd0, u_if.ones_out},   16'd8);
        u_if.out_ready = 1'b0;
        for (int k = 9; k <= 40; k++) begin
            if (k == 40) u_if.out_ready = 1'b1;
            tick();
            if (k == 39) check("bnd_hold_win", {14'd0, u_if.win_out}, 16'd0);
        end
        u_if.sn_valid  = 1'b0;
        u_if.out_ready = 1'b0;
        en = 1'b0;
        check("bnd_valid2",  {15'd0, u_if.out_valid},  16'd1);
        check("bnd_win2",    {14'd0, u_if.win_out},    16'd2);
        check("bnd_ones2",   {9'd0, u_if.ones_out},    16'd32);
        check("bnd_bip2",    {8'd0, u_if.bipolar_out}, 16'h20);
        check("bnd_no_ovr",  {15'd0, overrun},         16'd0);
        do_clr();

        // ---------------- reset mid-window ----------------
        win_sel = 2'd0;
        en = 1'b1;
        tick();
        u_if.sn_valid = 1'b1;
        u_if.sn_bit   = 1'b1;
        win_sel = 2'd1;
        for (int k = 0; k < 13; k++) tick();
        check("rmw_pre_valid", {15'd0, u_if.out_valid}, 16'd1);
        check("rmw_pre_busy",  {15'd0, busy},           16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmw_valid",   {15'd0, u_if.out_valid},  16'd0);
        check("rmw_ones",    {9'd0, u_if.ones_out},    16'd0);
        check("rmw_bip",     {8'd0, u_if.bipolar_out}, 16'd0);
        check("rmw_busy",    {15'd0, busy},            16'd0);
        u_if.sn_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        win_sel = 2'd1;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            u_if.sn_valid = 1'b1;
            u_if.sn_bit   = (i == 2 || i == 9 || i == 15) ? 1'b1 : 1'b0;
            tick();
        end
        u_if.sn_valid = 1'b0;
        check("rmw_fresh_valid", {15'd0, u_if.out_valid},  16'd1);
        check("rmw_fresh_ones",  {9'd0, u_if.ones_out},    16'd3);
        check("rmw_fresh_bip",   {8'd0, u_if.bipolar_out}, 16'hF6);
        check("rmw_fresh_win",   {14'd0, u_if.win_out},    16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
